// File: rtl/serial_display_rx_if.sv
// Serial display link plus parallel result bundle for serial_display_rx.
// The master drives the 4-wire link (CLK, DO, PEN, CLR); the slave is the receiver.
interface serial_display_rx_if #(parameter int WIDTH = 16);
    logic             s_clk;
    logic             s_do;
    logic             s_pen;
    logic             s_clr;
    logic [WIDTH-1:0] pdata;
    logic             valid;
    logic             frame_err;
    logic             busy;

    modport master (output s_clk, s_do, s_pen, s_clr,
                    input  pdata, valid, frame_err, busy);
    modport slave  (input  s_clk, s_do, s_pen, s_clr,
                    output pdata, valid, frame_err, busy);
endinterface

// File: rtl/serial_display_rx.sv
// Oversampling receiver for the display shift link: reassembles MSB-first frames into pdata.
// Optional SERIAL_RX_INVERT_EN: latch the bitwise inverse of the received frame.
module serial_display_rx #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input logic               clk,
    input logic               reset,
    serial_display_rx_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    logic             r_clk_s1, r_clk_s2, r_clk_prev;
    logic             r_pen_s1, r_pen_s2, r_pen_prev;
    logic             r_clr_s1, r_clr_s2;
    logic             r_do_s1, r_do_s2;
    state_t           r_state;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [TW-1:0]    r_idle;
    logic [WIDTH-1:0] r_pdata;
    logic             r_valid, r_ferr;

    logic             w_clk_rise, w_pen_rise;
    logic [WIDTH-1:0] w_sr_next;
    logic [CW-1:0]    w_cnt_next;
    logic [WIDTH-1:0] w_latch_val;

    assign w_clk_rise = r_clk_s2 & ~r_clk_prev;
    assign w_pen_rise = r_pen_s2 & ~r_pen_prev;

    // Post-shift view: a PEN edge in the same sample as the last CLK edge sees the new bit.
    assign w_sr_next  = w_clk_rise ? {r_sr[WIDTH-2:0], r_do_s2} : r_sr;
    assign w_cnt_next = !w_clk_rise       ? r_cnt :
                        (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

`ifdef SERIAL_RX_INVERT_EN
    assign w_latch_val = ~w_sr_next;
`else
    assign w_latch_val = w_sr_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_s1 <= 1'b0; r_clk_s2 <= 1'b0; r_clk_prev <= 1'b0;
            r_pen_s1 <= 1'b0; r_pen_s2 <= 1'b0; r_pen_prev <= 1'b0;
            r_clr_s1 <= 1'b1; r_clr_s2 <= 1'b1;
            r_do_s1  <= 1'b0; r_do_s2  <= 1'b0;
            r_state  <= ST_IDLE;
            r_sr     <= '0;
            r_cnt    <= '0;
            r_idle   <= '0;
            r_pdata  <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_clk_s1 <= bus.s_clk; r_clk_s2 <= r_clk_s1; r_clk_prev <= r_clk_s2;
            r_pen_s1 <= bus.s_pen; r_pen_s2 <= r_pen_s1; r_pen_prev <= r_pen_s2;
            r_clr_s1 <= bus.s_clr; r_clr_s2 <= r_clr_s1;
            r_do_s1  <= bus.s_do;  r_do_s2  <= r_do_s1;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;

            if (!r_clr_s2) begin
                // Clear swallows any edge seen in the same sample, silently.
                r_sr    <= '0;
                r_cnt   <= '0;
                r_idle  <= '0;
                r_pdata <= '0;
                r_state <= ST_IDLE;
            end else begin
                if (w_clk_rise) begin
                    r_sr   <= w_sr_next;
                    r_idle <= '0;
                end
                if (w_pen_rise) begin
                    if (w_cnt_next == CNT_FULL) begin
                        r_pdata <= w_latch_val;
                        r_valid <= 1'b1;
                    end else begin
                        r_ferr  <= 1'b1;
                    end
                    r_cnt   <= '0;
                    r_idle  <= '0;
                    r_state <= ST_IDLE;
                end else if (w_clk_rise) begin
                    r_cnt   <= w_cnt_next;
                    r_state <= ST_SHIFT;
                end else if (r_state == ST_SHIFT) begin
                    if (r_idle == TO_LAST) begin
                        r_cnt   <= '0;
                        r_idle  <= '0;
                        r_ferr  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_idle  <= r_idle + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.pdata     = r_pdata;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_ferr;
    assign bus.busy      = (r_cnt != '0);
endmodule
